// File: rtl/cpu_step_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_step_ctrl_if
//  Description : Signal bundle between the board/datapath side and the
//                step controller: raw key, mode/breakpoint controls, PC
//                feedback, and the step enable / status outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cpu_step_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             key_n;       // raw pushbutton, active-low, asynchronous
   logic             run_mode;    // 0 = manual step, 1 = free-run
   logic             bp_en;       // breakpoint enable
   logic [7:0]       bp_addr;     // breakpoint PC value
   logic [7:0]       pc;          // current PC from the PC register
   logic             step_en;     // one-cycle datapath enable pulse
   logic [CNT_W-1:0] step_count;  // number of step_en pulses, wraps
   logic             halted;      // free-run stopped at breakpoint
   logic             key_level;   // debounced key state, 1 = pressed

   // Board / datapath side: drives controls, observes step outputs
   modport master (
      output key_n, run_mode, bp_en, bp_addr, pc,
      input  step_en, step_count, halted, key_level
   );

   // Step controller side
   modport slave (
      input  key_n, run_mode, bp_en, bp_addr, pc,
      output step_en, step_count, halted, key_level
   );
endinterface
`default_nettype wire

// File: rtl/cpu_step_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_step_ctrl
//  Description : Clock-enable generator for the single-cycle datapath.
//                Synchronises and debounces the step pushbutton, issues
//                one-cycle step_en pulses either on a key press (manual)
//                or at a divided rate (free-run), and halts free-run when
//                the PC reaches an enabled breakpoint.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_step_ctrl #(
   parameter int DEBOUNCE_CYCLES = 500000,    // stable samples to accept a key change
   parameter int RUN_DIV         = 25000000,  // clk cycles per free-run step, >= 2
   parameter int CNT_W           = 16         // width of step_count
) (
   input  wire logic        clk,
   input  wire logic        iRST_N,
   cpu_step_ctrl_if.slave   bus
);

   // Counter widths sized to hold the terminal value
   localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;

   localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      S_STEP = 2'd0,   // manual: one pulse per debounced press
      S_RUN  = 2'd1,   // free-run: one pulse every RUN_DIV cycles
      S_HALT = 2'd2    // free-run parked at the breakpoint
   } state_t;

   // ------------------------------------------------------------------
   // Key path registers
   // ------------------------------------------------------------------
   logic            key_meta_q;    // first synchroniser stage
   logic            key_sync_q;    // second synchroniser stage
   logic [DB_W-1:0] db_cnt_q;      // consecutive samples disagreeing with key_level
   logic            key_level_q;   // debounced level, 1 = pressed
   logic            key_prev_q;    // key_level delayed one cycle for edge detect

   // ------------------------------------------------------------------
   // Step sequencer registers
   // ------------------------------------------------------------------
   state_t           state_q;
   logic [DIV_W-1:0] div_q;        // free-run rate divider
   logic             step_en_q;
   logic [CNT_W-1:0] step_count_q;
   logic             halted_q;

   // ------------------------------------------------------------------
   // Combinational helpers
   // ------------------------------------------------------------------
   logic key_s;      // synchronised key, 1 = pressed
   logic press;      // one-cycle strobe on debounced press
   logic bp_hit;     // PC sits on the enabled breakpoint
   logic div_wrap;   // divider is at its terminal count

   assign key_s    = ~key_sync_q;
   assign press    = key_level_q & ~key_prev_q;
   assign bp_hit   = bus.bp_en && (bus.pc == bus.bp_addr);
   assign div_wrap = (div_q == DIV_LAST);

   // Two-flop synchroniser; idles at 1 (key released) out of reset
   always_ff @(posedge clk or negedge iRST_N) begin
      if (!iRST_N) begin
         key_meta_q <= 1'b1;
         key_sync_q <= 1'b1;
      end else begin
         key_meta_q <= bus.key_n;
         key_sync_q <= key_meta_q;
      end
   end

   // Debounce: accept a new level only after DEBOUNCE_CYCLES disagreeing samples in a row
   always_ff @(posedge clk or negedge iRST_N) begin
      if (!iRST_N) begin
         db_cnt_q    <= '0;
         key_level_q <= 1'b0;
      end else if (key_s == key_level_q) begin
         db_cnt_q    <= '0;
      end else if (db_cnt_q == DB_LAST) begin
         db_cnt_q    <= '0;
         key_level_q <= key_s;
      end else begin
         db_cnt_q    <= db_cnt_q + DB_W'(1);
      end
   end

   // Delayed copy of the debounced level for rising-edge (press) detection
   always_ff @(posedge clk or negedge iRST_N) begin
      if (!iRST_N) begin
         key_prev_q <= 1'b0;
      end else begin
         key_prev_q <= key_level_q;
      end
   end

   // Step sequencer: mode handling, divider, breakpoint and registered outputs
   always_ff @(posedge clk or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q      <= S_STEP;
         div_q        <= '0;
         step_en_q    <= 1'b0;
         step_count_q <= '0;
         halted_q     <= 1'b0;
      end else begin
         // step_en is a strobe; only the branches below raise it
         step_en_q <= 1'b0;

         case (state_q)
            S_STEP: begin
               div_q    <= '0;
               halted_q <= 1'b0;
               // A mode change takes priority; a coincident press is dropped
               if (bus.run_mode) begin
                  state_q <= S_RUN;
               end else if (press) begin
                  step_en_q    <= 1'b1;
                  step_count_q <= step_count_q + CNT_ONE;
               end
            end

            S_RUN: begin
               // Presses are ignored while free-running
               if (!bus.run_mode) begin
                  state_q <= S_STEP;
                  div_q   <= '0;
               end else if (div_wrap) begin
                  div_q <= '0;
                  // PC is tested at the step point, so the breakpoint
                  // instruction is not executed in free-run
                  if (bp_hit) begin
                     state_q  <= S_HALT;
                     halted_q <= 1'b1;
                  end else begin
                     step_en_q    <= 1'b1;
                     step_count_q <= step_count_q + CNT_ONE;
                  end
               end else begin
                  div_q <= div_q + DIV_W'(1);
               end
            end

            S_HALT: begin
               div_q <= '0;
               if (!bus.run_mode) begin
                  state_q  <= S_STEP;
                  halted_q <= 1'b0;
               end else if (press) begin
                  // Single step past the breakpoint, then resume free-run
                  step_en_q    <= 1'b1;
                  step_count_q <= step_count_q + CNT_ONE;
                  halted_q     <= 1'b0;
                  state_q      <= S_RUN;
               end
            end

            default: begin
               state_q  <= S_STEP;
               div_q    <= '0;
               halted_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.step_en    = step_en_q;
   assign bus.step_count = step_count_q;
   assign bus.halted     = halted_q;
   assign bus.key_level  = key_level_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_step_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_step_ctrl
//  Description : Self-checking bench for cpu_step_ctrl. A cycle-level
//                behavioural model of the step controller predicts every
//                output; directed scenarios cover reset, bounce, manual
//                stepping, free-run, breakpoint, counter wrap and the
//                mode-change/press collision, followed by random stimulus.
//                A second instance with a 4-bit counter exercises wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_step_ctrl;

   localparam int DB  = 4;
   localparam int DIV = 5;

   logic       clk;
   logic       rst_n;
   logic       key_n;
   logic       run_mode;
   logic       bp_en;
   logic [7:0] bp_addr;
   logic [7:0] pc;
   logic       track_pc;

   int n_checks;
   int n_errors;

   cpu_step_ctrl_if #(.CNT_W(16)) bus_w ();
   cpu_step_ctrl_if #(.CNT_W(4))  bus_n ();

   assign bus_w.key_n    = key_n;
   assign bus_w.run_mode = run_mode;
   assign bus_w.bp_en    = bp_en;
   assign bus_w.bp_addr  = bp_addr;
   assign bus_w.pc       = pc;
   assign bus_n.key_n    = key_n;
   assign bus_n.run_mode = run_mode;
   assign bus_n.bp_en    = bp_en;
   assign bus_n.bp_addr  = bp_addr;
   assign bus_n.pc       = pc;

   cpu_step_ctrl #(.DEBOUNCE_CYCLES(DB), .RUN_DIV(DIV), .CNT_W(16)) u_dut (
      .clk    (clk),
      .iRST_N (rst_n),
      .bus    (bus_w)
   );

   cpu_step_ctrl #(.DEBOUNCE_CYCLES(DB), .RUN_DIV(DIV), .CNT_W(4)) u_dut_n (
      .clk    (clk),
      .iRST_N (rst_n),
      .bus    (bus_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ------------------------------------------------------------------
   // Behavioural reference model
   // ------------------------------------------------------------------
   typedef struct packed {
      logic        s0;       // newest synchronised sample of key_n
      logic        s1;       // oldest synchronised sample of key_n
      logic [31:0] mism;     // length of current disagreeing run
      logic        level;    // debounced level
      logic        prev;     // level one cycle earlier
      logic        running;  // free-run active
      logic        halted;   // parked at breakpoint
      logic [31:0] phase;    // cycles spent in the current free-run period
      logic        pulse;    // step_en
      logic [31:0] count;    // total pulses, unbounded
   } model_t;

   model_t m;

   function automatic model_t model_reset();
      model_t r;
      r         = '0;
      r.s0      = 1'b1;
      r.s1      = 1'b1;
      return r;
   endfunction

   function automatic model_t model_next(model_t cur, logic kn, logic rm,
                                         logic be, logic [7:0] ba, logic [7:0] p);
      model_t nx;
      logic   ks;
      logic   prs;
      nx       = cur;
      ks       = ~cur.s1;
      prs      = cur.level && !cur.prev;
      nx.s0    = kn;
      nx.s1    = cur.s0;
      nx.prev  = cur.level;
      nx.pulse = 1'b0;
      if (ks != cur.level) begin
         nx.mism = cur.mism + 1;
         if (nx.mism == DB) begin
            nx.level = ks;
            nx.mism  = 0;
         end
      end else begin
         nx.mism = 0;
      end
      if (cur.halted) begin
         if (!rm) begin
            nx.halted = 1'b0;
         end else if (prs) begin
            nx.pulse   = 1'b1;
            nx.halted  = 1'b0;
            nx.running = 1'b1;
            nx.phase   = 0;
         end
      end else if (cur.running) begin
         if (!rm) begin
            nx.running = 1'b0;
            nx.phase   = 0;
         end else begin
            nx.phase = cur.phase + 1;
            if (nx.phase == DIV) begin
               nx.phase = 0;
               if (be && (p == ba)) begin
                  nx.halted  = 1'b1;
                  nx.running = 1'b0;
               end else begin
                  nx.pulse = 1'b1;
               end
            end
         end
      end else begin
         if (rm) begin
            nx.running = 1'b1;
            nx.phase   = 0;
         end else if (prs) begin
            nx.pulse = 1'b1;
         end
      end
      if (nx.pulse) nx.count = cur.count + 1;
      return nx;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m <= model_reset();
      else        m <= model_next(m, key_n, run_mode, bp_en, bp_addr, pc);
   end

   // ------------------------------------------------------------------
   // Checking helpers
   // ------------------------------------------------------------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cmp_all();
      chk("step_en",        32'(bus_w.step_en),    32'(m.pulse));
      chk("step_count",     32'(bus_w.step_count), {16'd0, m.count[15:0]});
      chk("halted",         32'(bus_w.halted),     32'(m.halted));
      chk("key_level",      32'(bus_w.key_level),  32'(m.level));
      chk("narrow_step_en", 32'(bus_n.step_en),    32'(m.pulse));
      chk("narrow_count",   32'(bus_n.step_count), {28'd0, m.count[3:0]});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cmp_all();
      if (track_pc) pc = m.count[7:0];
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic press_key();
      key_n = 1'b0;
      ticks(8);
      key_n = 1'b1;
      ticks(8);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      cmp_all();
      ticks(2);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // ------------------------------------------------------------------
   // Directed sequence followed by random stimulus
   // ------------------------------------------------------------------
   initial begin
      int pulses;
      int last;
      bit found;
      logic [31:0] c0;

      n_checks = 0;
      n_errors = 0;
      rst_n    = 1'b1;
      key_n    = 1'b1;
      run_mode = 1'b0;
      bp_en    = 1'b0;
      bp_addr  = 8'h00;
      pc       = 8'h00;
      track_pc = 1'b0;

      // Reset state
      #2 rst_n = 1'b0;
      #1;
      chk("rst_step_en",   32'(bus_w.step_en),    32'd0);
      chk("rst_count",     32'(bus_w.step_count), 32'd0);
      chk("rst_halted",    32'(bus_w.halted),     32'd0);
      chk("rst_key_level", 32'(bus_w.key_level),  32'd0);
      ticks(3);
      @(negedge clk);
      rst_n = 1'b1;
      ticks(2);
      chk("rel_count", 32'(bus_w.step_count), 32'd0);

      // Bounce: short lows never change the debounced level
      key_n = 1'b0; ticks(2);
      key_n = 1'b1; ticks(1);
      key_n = 1'b0; ticks(3);
      key_n = 1'b1; ticks(6);
      chk("bounce_level", 32'(bus_w.key_level),  32'd0);
      chk("bounce_count", 32'(bus_w.step_count), 32'd0);
      key_n = 1'b0; ticks(6);
      chk("clean_level",  32'(bus_w.key_level),  32'd1);
      key_n = 1'b1; ticks(8);
      chk("clean_count",  32'(bus_w.step_count), 32'd1);

      // Manual stepping ignores the breakpoint
      bp_en = 1'b1; bp_addr = 8'h21; pc = 8'h21;
      for (int k = 0; k < 3; k++) press_key();
      chk("manual_count",  32'(bus_w.step_count), 32'd4);
      chk("manual_halted", 32'(bus_w.halted),     32'd0);

      // Free-run: five evenly spaced pulses
      bp_en = 1'b0; run_mode = 1'b1;
      pulses = 0; last = -1;
      for (int i = 0; i < 28; i++) begin
         tick();
         if (bus_w.step_en) begin
            if (last >= 0) chk("run_spacing", 32'(i - last), 32'd5);
            last = i;
            pulses++;
         end
      end
      chk("run_pulses", 32'(pulses), 32'd5);
      chk("run_count",  32'(bus_w.step_count), 32'd9);

      // Reset asserted while step_en is high
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         tick();
         if (bus_w.step_en) found = 1'b1;
      end
      chk("pulse_seen", 32'(found), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("midrst_step_en", 32'(bus_w.step_en),    32'd0);
      chk("midrst_count",   32'(bus_w.step_count), 32'd0);
      chk("midrst_halted",  32'(bus_w.halted),     32'd0);
      run_mode = 1'b0;
      ticks(2);
      @(negedge clk);
      rst_n = 1'b1;
      ticks(6);
      chk("no_replay", 32'(bus_w.step_count), 32'd0);

      // Breakpoint at PC 3 with PC following the step count
      track_pc = 1'b1; bp_en = 1'b1; bp_addr = 8'h03; run_mode = 1'b1;
      ticks(30);
      chk("bp_halted", 32'(bus_w.halted),     32'd1);
      chk("bp_count",  32'(bus_w.step_count), 32'd3);
      key_n = 1'b0;
      for (int i = 0; i < 20 && bus_w.halted; i++) tick();
      chk("resume_halted", 32'(bus_w.halted),     32'd0);
      chk("resume_count",  32'(bus_w.step_count), 32'd4);
      key_n = 1'b1;
      ticks(6);
      chk("resume_run", 32'(bus_w.step_count), 32'd5);
      chk("resume_nohalt", 32'(bus_w.halted), 32'd0);

      // Counter wrap on the narrow instance
      track_pc = 1'b0; bp_en = 1'b0; run_mode = 1'b0;
      do_reset();
      run_mode = 1'b1;
      for (int i = 0; i < 200 && m.count != 15; i++) tick();
      chk("pre_wrap_n", 32'(bus_n.step_count), 32'd15);
      for (int i = 0; i < 20 && m.count != 16; i++) tick();
      chk("wrap_n", 32'(bus_n.step_count), 32'd0);
      chk("wrap_w", 32'(bus_w.step_count), 32'd16);

      // Mode change on the same cycle as a press: no pulse, back to manual
      key_n = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         if (m.level && !m.prev) begin
            run_mode = 1'b0;
            found    = 1'b1;
         end
      end
      chk("collide_seen", 32'(found), 32'd1);
      c0 = m.count;
      ticks(2);
      key_n = 1'b1;
      ticks(8);
      chk("collide_nopulse", 32'(bus_w.step_count), c0);
      press_key();
      chk("collide_manual", 32'(bus_w.step_count), c0 + 32'd1);

      // Random stimulus against the model
      do_reset();
      track_pc = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 9) == 0)  key_n    = ~key_n;
         if ($urandom_range(0, 79) == 0) run_mode = ~run_mode;
         if ($urandom_range(0, 15) == 0) bp_en    = $urandom_range(0, 1) == 1;
         if ($urandom_range(0, 15) == 0) bp_addr  = m.count[7:0] + 8'($urandom_range(0, 3));
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
